// File: rtl/comparator_tally_pkg.sv
// Shared flag codes, FSM encoding and outcome helpers for comparator_tally.
package comparator_tally_pkg;

  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_REPORT  = 1'b1
  } state_t;

  // Tally slot index per outcome category
  localparam int NUM_CAT = 4;
  localparam logic [1:0] CAT_GT  = 2'd0;
  localparam logic [1:0] CAT_EQ  = 2'd1;
  localparam logic [1:0] CAT_LT  = 2'd2;
  localparam logic [1:0] CAT_ERR = 2'd3;

  // Anything that is not an exact one-hot code lands in the error slot
  function automatic logic [1:0] flag_cat(input logic [2:0] f);
    case (f)
      FLAG_GT: flag_cat = CAT_GT;
      FLAG_EQ: flag_cat = CAT_EQ;
      FLAG_LT: flag_cat = CAT_LT;
      default: flag_cat = CAT_ERR;
    endcase
  endfunction

  // One-hot flag of the strictly largest count; any tie for the top yields 0
  function automatic logic [2:0] majority3(input int g, input int e, input int l);
    if (g > e && g > l)      majority3 = FLAG_GT;
    else if (e > g && e > l) majority3 = FLAG_EQ;
    else if (l > g && l > e) majority3 = FLAG_LT;
    else                     majority3 = 3'b000;
  endfunction

endpackage

// File: rtl/comparator_tally_counter.sv
// Up-counter with synchronous clear priority over enable.
module tally_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Clear wins; never wraps because the window bounds the count
  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/comparator_tally.sv
// Windowed tally of comparator outcomes with held report and change pulse.
module comparator_tally
  import comparator_tally_pkg::*;
#(
  parameter  int WINDOW = 8,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [2:0]       i_flags,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [CNT_W-1:0] o_cnt_gt,
  output logic [CNT_W-1:0] o_cnt_eq,
  output logic [CNT_W-1:0] o_cnt_lt,
  output logic [CNT_W-1:0] o_cnt_err,
  output logic [2:0]       o_majority,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_change
);

  state_t                          state;
  logic [NUM_CAT-1:0][CNT_W-1:0]   cnt;
  logic [NUM_CAT-1:0]              inc;
  logic [CNT_W+1:0]                total;
  logic [2:0]                      hist;
  logic                            hist_vld;
  logic                            accept;
  logic                            rpt_hs;
  logic                            window_done;
  logic                            cnt_clr;
  logic [2:0]                      maj_nxt;

  assign accept      = (state == S_COLLECT) && o_ready && i_valid;
  assign rpt_hs      = (state == S_REPORT) && o_valid && i_ready;
  assign cnt_clr     = !i_rst_n || i_clear || rpt_hs;
  assign window_done = accept && (total == (CNT_W+2)'(WINDOW - 1));

  // Route the accepted sample to exactly one tally slot
  always_comb begin
    inc = '0;
    if (accept) inc[flag_cat(i_flags)] = 1'b1;
  end

  // Samples accepted so far in this window
  always_comb begin
    total = '0;
    for (int k = 0; k < NUM_CAT; k++) total = total + (CNT_W+2)'(cnt[k]);
  end

  // Majority from the post-accept counts so it lands with the report
  always_comb begin
    maj_nxt = majority3(int'(cnt[CAT_GT]) + int'(inc[CAT_GT]),
                        int'(cnt[CAT_EQ]) + int'(inc[CAT_EQ]),
                        int'(cnt[CAT_LT]) + int'(inc[CAT_LT]));
  end

  for (genvar g = 0; g < NUM_CAT; g++) begin : g_cnt
    tally_counter #(.W(CNT_W)) u_cnt (
      .clk (i_clk),
      .clr (cnt_clr),
      .en  (inc[g]),
      .cnt (cnt[g])
    );
  end

  assign o_cnt_gt  = cnt[CAT_GT];
  assign o_cnt_eq  = cnt[CAT_EQ];
  assign o_cnt_lt  = cnt[CAT_LT];
  assign o_cnt_err = cnt[CAT_ERR];

  // Collect/report FSM with registered handshake, majority and change pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_COLLECT;
      o_ready    <= 1'b0;
      o_valid    <= 1'b0;
      o_majority <= 3'b000;
      o_change   <= 1'b0;
      hist       <= 3'b000;
      hist_vld   <= 1'b0;
    end else if (i_clear) begin
      state      <= S_COLLECT;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_majority <= 3'b000;
      o_change   <= 1'b0;
      hist_vld   <= 1'b0;
    end else begin
      o_change <= 1'b0;
      case (state)
        S_COLLECT: begin
          o_ready <= 1'b1;
          if (accept) begin
            o_change <= hist_vld && (i_flags != hist);
            hist     <= i_flags;
            hist_vld <= 1'b1;
            if (window_done) begin
              state      <= S_REPORT;
              o_ready    <= 1'b0;
              o_valid    <= 1'b1;
              o_majority <= maj_nxt;
            end
          end
        end
        S_REPORT: begin
          if (rpt_hs) begin
            state      <= S_COLLECT;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
            o_majority <= 3'b000;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_tally.sv
// Scoreboard bench for comparator_tally with a 4-sample window.
module tb_comparator_tally;
  import comparator_tally_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n, clear, valid, rdy_in;
  logic [2:0]    flags;
  logic          ready, rvalid, change;
  logic [CW-1:0] c_gt, c_eq, c_lt, c_err;
  logic [2:0]    maj;

  typedef struct {
    int         gt, eq, lt, err;
    logic [2:0] maj;
  } rep_t;

  rep_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         m_cnt[4];
  logic [2:0] m_hist;
  bit         m_hist_vld;

  comparator_tally #(.WINDOW(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_flags(flags),
    .i_valid(valid), .o_ready(ready), .o_cnt_gt(c_gt), .o_cnt_eq(c_eq),
    .o_cnt_lt(c_lt), .o_cnt_err(c_err), .o_majority(maj), .o_valid(rvalid),
    .i_ready(rdy_in), .o_change(change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_hist_vld = 0;
  endtask

  // Majority by max-and-uniqueness, independent of the RTL formulation
  function automatic logic [2:0] exp_maj(input int g, input int e, input int l);
    int m, n;
    m = g;
    if (e > m) m = e;
    if (l > m) m = l;
    n = (g == m) + (e == m) + (l == m);
    if (n != 1) return 3'b000;
    if (g == m) return 3'b100;
    if (e == m) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_counts(input string nm, input int g, input int e, input int l, input int r);
    checks++;
    if (c_gt !== CW'(g) || c_eq !== CW'(e) || c_lt !== CW'(l) || c_err !== CW'(r)) begin
      errors++;
      $display("FAIL %s counts got gt=%0d eq=%0d lt=%0d err=%0d want %0d %0d %0d %0d",
               nm, c_gt, c_eq, c_lt, c_err, g, e, l, r);
    end
  endtask

  task automatic check_hs(input string nm, input logic rd, input logic vl);
    checks++;
    if (ready !== rd || rvalid !== vl) begin
      errors++;
      $display("FAIL %s handshake got ready=%b valid=%b want ready=%b valid=%b", nm, ready, rvalid, rd, vl);
    end
  endtask

  // Drive one sample through an accepting edge; model push on window completion
  task automatic accept_one(input logic [2:0] f);
    logic exp_chg;
    int   c;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b want 1", ready);
    end
    exp_chg = m_hist_vld && (f != m_hist);
    m_hist = f; m_hist_vld = 1;
    case (f)
      3'b100:  c = 0;
      3'b010:  c = 1;
      3'b001:  c = 2;
      default: c = 3;
    endcase
    m_cnt[c]++;
    if (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] == W) begin
      rep_t r;
      r.gt = m_cnt[0]; r.eq = m_cnt[1]; r.lt = m_cnt[2]; r.err = m_cnt[3];
      r.maj = exp_maj(r.gt, r.eq, r.lt);
      sb.push_back(r);
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end
    valid = 1; flags = f;
    tick();
    valid = 0;
    checks++;
    if (change !== exp_chg) begin
      errors++;
      $display("FAIL change flags=%b got %b want %b", f, change, exp_chg);
    end
  endtask

  // Report must be up now; pop the scoreboard and compare
  task automatic check_report(input string nm);
    rep_t r;
    check_hs({nm, "_rpt"}, 1'b0, 1'b1);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got report want none", nm);
      return;
    end
    r = sb.pop_front();
    check_counts(nm, r.gt, r.eq, r.lt, r.err);
    if (maj !== r.maj) begin
      errors++;
      $display("FAIL %s majority got %b want %b", nm, maj, r.maj);
    end
  endtask

  task automatic check_idle(input string nm);
    check_hs(nm, 1'b1, 1'b0);
    check_counts(nm, 0, 0, 0, 0);
    checks++;
    if (maj !== 3'b000) begin
      errors++;
      $display("FAIL %s majority_idle got %b want 000", nm, maj);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; valid = 1; flags = 3'b100; rdy_in = 0;
    repeat (3) tick();
    check_hs("reset", 1'b0, 1'b0);
    check_counts("reset", 0, 0, 0, 0);
    checks++;
    if (change !== 1'b0 || maj !== 3'b000) begin
      errors++;
      $display("FAIL reset_misc got change=%b maj=%b want 0 000", change, maj);
    end
    rst_n = 1;
    tick();
    valid = 0;
    check_idle("reset_release");
    model_reset();
  endtask

  task automatic test_basic_window();
    rdy_in = 1;
    accept_one(3'b100); accept_one(3'b100); accept_one(3'b010); accept_one(3'b001);
    check_report("basic");
    tick();
    check_idle("basic_after");
  endtask

  task automatic test_backpressure();
    rdy_in = 0;
    accept_one(3'b010); accept_one(3'b010); accept_one(3'b010); accept_one(3'b100);
    check_report("bp");
    valid = 1; flags = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_hs("bp_hold", 1'b0, 1'b1);
      check_counts("bp_hold", 1, 3, 0, 0);
    end
    valid = 0; rdy_in = 1;
    tick();
    check_idle("bp_release");
  endtask

  task automatic test_errors_tie();
    rdy_in = 1;
    accept_one(3'b011); accept_one(3'b000); accept_one(3'b010); accept_one(3'b001);
    check_report("err_tie");
    tick();
    check_idle("err_tie_after");
  endtask

  task automatic test_clear();
    rdy_in = 0;
    accept_one(3'b100); accept_one(3'b001);
    check_counts("pre_clear", 1, 0, 1, 0);
    clear = 1; valid = 1; flags = 3'b010;
    tick();
    clear = 0; valid = 0;
    model_reset();
    check_idle("clear");
    checks++;
    if (change !== 1'b0) begin
      errors++;
      $display("FAIL clear_change got %b want 0", change);
    end
    accept_one(3'b010);
    check_counts("post_clear", 0, 1, 0, 0);
  endtask

  task automatic test_reset_in_report();
    accept_one(3'b100); accept_one(3'b100); accept_one(3'b100);
    check_report("pre_rst");
    rst_n = 0;
    tick();
    rst_n = 1;
    check_hs("mid_rst", 1'b0, 1'b0);
    check_counts("mid_rst", 0, 0, 0, 0);
    tick();
    model_reset();
    check_idle("mid_rst_release");
  endtask

  task automatic test_back_to_back();
    rdy_in = 1;
    accept_one(3'b001); accept_one(3'b001); accept_one(3'b001); accept_one(3'b100);
    check_report("b2b_1");
    tick();
    accept_one(3'b111); accept_one(3'b010); accept_one(3'b010); accept_one(3'b100);
    check_report("b2b_2");
    tick();
    check_idle("b2b_after");
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_window();
    test_backpressure();
    test_errors_tie();
    test_clear();
    test_reset_in_report();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
